messbauer_spectrum_accumulator: RTL and testbench

- Acquisition stage directly downstream of messbauer_generator and messbauer_diff_discriminator_signals.
- Consumes their start, channel, lower_threshold and upper_threshold pulses.
- Each accepted event (lower crossed, upper not) is counted into a per-channel histogram bin, giving the Mossbauer spectrum across velocity channels.
- Host-side read port and clear sweep let the test environment self-check generator/discriminator output on silicon.

---
 rtl/messbauer_pkg.sv | 21 ++
 rtl/messbauer_pulse_sync.sv | 38 +++
 rtl/messbauer_spectrum_accumulator.sv | 234 +++++++++++++++++++++++
 tb/tb_messbauer_spectrum_accumulator.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/messbauer_pkg.sv
// Shared definitions for the Mossbauer spectrum accumulator.
//   state_t : RMW / clear sequencer states (IDLE, RD, WR, CLR)
//   clog2   : ceiling log2, used to size the bin address from CHANNEL_NUMBER
package messbauer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_CLR  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/messbauer_pulse_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// Input-to-edge latency is three aclk cycles.
//   aclk    : system clock
//   areset  : synchronous active-high reset
//   i_pulse : asynchronous pulse input
//   o_edge  : one-cycle strobe on each synchronised rising edge
//   o_level : synchronised level, time-aligned with o_edge
module messbauer_pulse_sync (
  input  logic aclk,
  input  logic areset,
  input  logic i_pulse,
  output logic o_edge,
  output logic o_level
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_edge;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_meta <= i_pulse;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_edge <= r_sync & ~r_prev;
    end
  end

  assign o_edge  = r_edge;
  assign o_level = r_prev;

endmodule

// File: rtl/messbauer_spectrum_accumulator.sv
// Mossbauer spectrum accumulator: counts qualified discriminator events per
// velocity channel into a block-RAM histogram, with a host read port and a
// clear sweep.
//   aclk, areset            : clock, synchronous active-high reset
//   start, channel          : sweep start / channel advance pulses (async)
//   lower_/upper_threshold  : discriminator crossings (async)
//   clear                   : one-cycle request to zero bins and counters
//   rd_addr / rd_data       : host bin read, one cycle latency
//   sweep_count             : completed sweeps (wraps)
//   busy                    : clear sweep or read-modify-write in progress
//   overflow                : sticky; a bin or the accumulator saturated, or
//                             a channel edge was lost
module messbauer_spectrum_accumulator
  import messbauer_pkg::*;
#(
  parameter int CHANNEL_NUMBER = 512,
  parameter int COUNTER_WIDTH  = 16,
  parameter int SWEEP_WIDTH    = 16,
  parameter int WINDOW         = 4
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             start,
  input  logic                             channel,
  input  logic                             lower_threshold,
  input  logic                             upper_threshold,
  input  logic                             clear,
  input  logic [clog2(CHANNEL_NUMBER)-1:0] rd_addr,
  output logic [COUNTER_WIDTH-1:0]         rd_data,
  output logic [SWEEP_WIDTH-1:0]           sweep_count,
  output logic                             busy,
  output logic                             overflow
);

  localparam int                     AW       = clog2(CHANNEL_NUMBER);
  localparam logic [AW-1:0]          LAST_IDX = AW'(CHANNEL_NUMBER - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [3:0]             WIN_LOAD = 4'(WINDOW);

  // Pulse conditioning: bit 0 start, 1 channel, 2 lower, 3 upper.
  logic [3:0] w_raw, w_edge, w_level;
  logic       w_unused_levels;
  assign w_raw = {upper_threshold, lower_threshold, channel, start};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      messbauer_pulse_sync u_sync (
        .aclk    (aclk),
        .areset  (areset),
        .i_pulse (w_raw[gi]),
        .o_edge  (w_edge[gi]),
        .o_level (w_level[gi])
      );
    end
  endgenerate

  // Only the upper discriminator level takes part in qualification.
  assign w_unused_levels = ^w_level[2:0];

  state_t                   r_state, w_state_next;
  logic [AW-1:0]            r_idx, r_pend_idx, r_hold_idx, r_clr_addr;
  logic [COUNTER_WIDTH-1:0] r_acc, r_pend_val, r_hold_val, r_mem_q, r_rd_data;
  logic [SWEEP_WIDTH-1:0]   r_sweep;
  logic [3:0]               r_win;
  logic r_veto, r_acquiring, r_done, r_overflow, r_clr_req;
  logic r_hold_valid, r_hold_serving;

  logic [COUNTER_WIDTH-1:0] r_mem [CHANNEL_NUMBER];

  logic w_clr_go, w_ops_ok, w_start_edge, w_ch_edge, w_lower_edge;
  logic w_armed, w_veto_now, w_expire, w_acc_sat;
  logic w_commit, w_launch, w_queue, w_accept, w_lost, w_drain, w_last_commit;
  logic [COUNTER_WIDTH-1:0] w_acc_now, w_wr_data, w_mem_wdata;
  logic [COUNTER_WIDTH:0]   w_sum;
  logic [AW-1:0]            w_mem_addr;
  logic                     w_mem_we;

  // A clear starts only from IDLE; otherwise it is parked in r_clr_req until
  // the running RMW returns. Pulse edges are ignored while clearing.
  assign w_clr_go     = (r_state == ST_IDLE) & (clear | r_clr_req);
  assign w_ops_ok     = (r_state != ST_CLR) & ~w_clr_go;
  assign w_start_edge = w_edge[0] & w_ops_ok;
  assign w_ch_edge    = w_edge[1] & w_ops_ok;
  assign w_lower_edge = w_edge[2] & w_ops_ok & r_acquiring;

  // Event window: armed while r_win != 0; counts on the last armed cycle.
  assign w_armed    = (r_win != 4'd0);
  assign w_veto_now = r_veto | w_edge[3] | w_level[3];
  assign w_expire   = w_ops_ok & r_acquiring & (r_win == 4'd1) & ~w_veto_now & ~w_lower_edge;
  assign w_acc_sat  = (r_acc == CNT_MAX);
  assign w_acc_now  = (w_expire && !w_acc_sat) ? r_acc + 1'b1 : r_acc;

  // Channel commit: launch straight into RD when free, else park in the
  // one-deep hold slot. The hold slot stays occupied until its own write
  // completes, so a further edge in that time is dropped entirely.
  assign w_commit      = w_ch_edge & r_acquiring;
  assign w_launch      = w_commit & (r_state == ST_IDLE) & ~r_hold_valid;
  assign w_queue       = w_commit & ~w_launch & ~r_hold_valid;
  assign w_lost        = w_commit & ~w_launch & r_hold_valid;
  assign w_accept      = w_launch | w_queue;
  assign w_last_commit = w_accept & (r_idx == LAST_IDX);
  assign w_drain       = (r_state == ST_IDLE) & r_hold_valid & ~r_hold_serving & ~w_clr_go;

  assign w_sum     = {1'b0, r_mem_q} + {1'b0, r_pend_val};
  assign w_wr_data = w_sum[COUNTER_WIDTH] ? CNT_MAX : w_sum[COUNTER_WIDTH-1:0];

  // Writes are suppressed under reset so an aborted RMW leaves the bin as-is.
  assign w_mem_we    = ~areset & ((r_state == ST_WR) | (r_state == ST_CLR));
  assign w_mem_addr  = (r_state == ST_CLR) ? r_clr_addr : r_pend_idx;
  assign w_mem_wdata = (r_state == ST_CLR) ? '0 : w_wr_data;

  always_ff @(posedge aclk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
    r_mem_q <= r_mem[r_pend_idx];
  end

  always_ff @(posedge aclk) begin
    if (areset) r_rd_data <= '0;
    else        r_rd_data <= r_mem[rd_addr];
  end

  always_ff @(posedge aclk) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_go)                w_state_next = ST_CLR;
        else if (w_launch || w_drain) w_state_next = ST_RD;
      end
      ST_RD:   w_state_next = ST_WR;
      ST_WR:   w_state_next = ST_IDLE;
      ST_CLR:  if (r_clr_addr == LAST_IDX) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_idx <= '0; r_pend_idx <= '0; r_hold_idx <= '0; r_clr_addr <= '0;
      r_acc <= '0; r_pend_val <= '0; r_hold_val <= '0; r_sweep <= '0;
      r_win <= '0; r_veto <= 1'b0; r_acquiring <= 1'b0; r_done <= 1'b0;
      r_overflow <= 1'b0; r_clr_req <= 1'b0;
      r_hold_valid <= 1'b0; r_hold_serving <= 1'b0;
    end else begin
      if (w_lower_edge) begin
        r_win  <= WIN_LOAD;
        r_veto <= 1'b0;
      end else if (w_armed) begin
        r_win  <= r_win - 1'b1;
        r_veto <= w_veto_now;
      end
      r_acc <= w_acc_now;
      if (w_expire && w_acc_sat) r_overflow <= 1'b1;

      if (clear && !w_clr_go && r_state != ST_CLR) r_clr_req <= 1'b1;

      if (w_accept) begin
        if (w_launch) begin
          r_pend_idx <= r_idx;
          r_pend_val <= w_acc_now;
        end else begin
          r_hold_idx   <= r_idx;
          r_hold_val   <= w_acc_now;
          r_hold_valid <= 1'b1;
        end
        r_acc <= '0;
        if (r_idx == LAST_IDX) begin
          r_acquiring <= 1'b0;
          r_done      <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_lost) r_overflow <= 1'b1;

      if (w_drain) begin
        r_pend_idx     <= r_hold_idx;
        r_pend_val     <= r_hold_val;
        r_hold_serving <= 1'b1;
      end

      if (r_state == ST_WR) begin
        if (w_sum[COUNTER_WIDTH]) r_overflow <= 1'b1;
        if (r_hold_serving) begin
          r_hold_serving <= 1'b0;
          r_hold_valid   <= 1'b0;
        end
      end

      // Placed after the commit so a coincident channel edge lands on the
      // old idx first; a pending window is discarded with the old sweep.
      if (w_start_edge) begin
        r_idx       <= '0;
        r_acquiring <= 1'b1;
        r_acc       <= '0;
        r_win       <= '0;
        r_veto      <= 1'b0;
        r_done      <= 1'b0;
        if (r_done || w_last_commit) r_sweep <= r_sweep + 1'b1;
      end

      if (w_clr_go) begin
        r_clr_req      <= 1'b0;
        r_clr_addr     <= '0;
        r_hold_valid   <= 1'b0;
        r_hold_serving <= 1'b0;
      end

      if (r_state == ST_CLR) begin
        r_clr_addr <= r_clr_addr + 1'b1;
        if (r_clr_addr == LAST_IDX) begin
          r_sweep     <= '0;
          r_overflow  <= 1'b0;
          r_acquiring <= 1'b0;
          r_done      <= 1'b0;
          r_idx       <= '0;
          r_acc       <= '0;
          r_win       <= '0;
          r_veto      <= 1'b0;
        end
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign sweep_count = r_sweep;
  assign busy        = (r_state != ST_IDLE) | r_hold_valid | r_clr_req;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_messbauer_spectrum_accumulator.sv
module tb_messbauer_spectrum_accumulator;

  logic aclk = 1'b0;
  always #10 aclk = ~aclk;

  // Instance A: default parameters (512 bins, 16-bit bins, WINDOW=4).
  logic        areset, start, channel, lower_threshold, upper_threshold, clear;
  logic [8:0]  rd_addr;
  logic [15:0] rd_data, sweep_count;
  logic        busy, overflow;

  // Instance B: 8 bins of 4 bits, for saturation.
  logic        b_areset, b_start, b_channel, b_lower, b_upper, b_clear;
  logic [2:0]  b_rd_addr;
  logic [3:0]  b_rd_data;
  logic [15:0] b_sweep_count;
  logic        b_busy, b_overflow;

  int checks = 0;
  int errors = 0;

  messbauer_spectrum_accumulator dut (
    .aclk(aclk), .areset(areset), .start(start), .channel(channel),
    .lower_threshold(lower_threshold), .upper_threshold(upper_threshold),
    .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
    .sweep_count(sweep_count), .busy(busy), .overflow(overflow)
  );

  messbauer_spectrum_accumulator #(.CHANNEL_NUMBER(8), .COUNTER_WIDTH(4)) dut_b (
    .aclk(aclk), .areset(b_areset), .start(b_start), .channel(b_channel),
    .lower_threshold(b_lower), .upper_threshold(b_upper),
    .clear(b_clear), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .sweep_count(b_sweep_count), .busy(b_busy), .overflow(b_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // 0 start, 1 channel, 2 lower, 3 upper, 4 b_start, 5 b_channel, 6 b_lower
  task automatic pulse(input int which);
    case (which)
      0: start = 1'b1;           1: channel = 1'b1;
      2: lower_threshold = 1'b1; 3: upper_threshold = 1'b1;
      4: b_start = 1'b1;         5: b_channel = 1'b1;
      default: b_lower = 1'b1;
    endcase
    @(negedge aclk);
    start = 1'b0; channel = 1'b0; lower_threshold = 1'b0; upper_threshold = 1'b0;
    b_start = 1'b0; b_channel = 1'b0; b_lower = 1'b0;
  endtask

  task automatic read_a(input int addr, input logic [31:0] exp, input string tag);
    rd_addr = 9'(addr);
    tick(1);
    check(tag, rd_data, exp);
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; channel = 1'b0; lower_threshold = 1'b0;
    upper_threshold = 1'b0; clear = 1'b0; rd_addr = '0;
    b_areset = 1'b1; b_start = 1'b0; b_channel = 1'b0; b_lower = 1'b0;
    b_upper = 1'b0; b_clear = 1'b0; b_rd_addr = '0;
    tick(4);
    check("rst_busy", busy, 0);
    check("rst_sweep", sweep_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_data", rd_data, 0);
    check("b_rst_busy", b_busy, 0);
    areset = 1'b0; b_areset = 1'b0;
    tick(1);

    // Clear the whole memory, then every bin reads zero.
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clear_busy", busy, 1);
    wait_idle_a("clear_done");
    for (int i = 0; i < 512; i++) read_a(i, 0, $sformatf("bin%0d_after_clear", i));
    check("sweep_after_clear", sweep_count, 0);

    // Full sweep: three clean events per channel.
    pulse(0); tick(5);
    for (int ch = 0; ch < 512; ch++) begin
      repeat (3) begin pulse(2); tick(10); end
      pulse(1); tick(8);
    end
    tick(4);
    check("sweep_before_restart", sweep_count, 0);
    pulse(0); tick(5);
    check("sweep_after_restart", sweep_count, 1);
    for (int i = 0; i < 512; i++) read_a(i, 3, $sformatf("bin%0d_sweep", i));

    // Reset in the WR cycle of bin 7, then clear.
    repeat (7) begin pulse(1); tick(8); end
    pulse(2); tick(10);
    pulse(1); tick(4);
    check("wr_busy", busy, 1);
    areset = 1'b1; tick(1);
    check("abort_busy", busy, 0);
    check("abort_sweep", sweep_count, 0);
    check("abort_overflow", overflow, 0);
    check("abort_rd_data", rd_data, 0);
    areset = 1'b0; tick(1);
    read_a(0, 3, "bin0_kept_by_reset");
    clear = 1'b1; tick(1); clear = 1'b0;
    wait_idle_a("clear2_done");
    read_a(0, 0, "bin0_after_clear2");
    read_a(7, 0, "bin7_after_clear2");
    check("sweep_after_clear2", sweep_count, 0);

    // Veto: upper 2 cycles after lower is inside the window, 6 is outside.
    pulse(0); tick(5);
    pulse(2); tick(1); pulse(3); tick(10);
    pulse(1); tick(8);
    pulse(2); tick(5); pulse(3); tick(10);
    pulse(1); tick(8);
    read_a(0, 0, "bin0_vetoed");
    read_a(1, 1, "bin1_late_upper");
    check("no_overflow_yet", overflow, 0);

    // Three channel edges 2 cycles apart: bins 2,3 committed, third lost.
    pulse(2); tick(10);
    pulse(1); tick(1); pulse(1); tick(1); pulse(1); tick(10);
    check("lost_edge_overflow", overflow, 1);
    pulse(2); tick(10);
    pulse(1); tick(8);
    read_a(2, 1, "bin2_first_commit");
    read_a(3, 0, "bin3_second_commit");
    read_a(4, 1, "bin4_after_lost");
    read_a(5, 0, "bin5_untouched");

    // Instance B: 20 events saturate a 4-bit bin at 15.
    b_clear = 1'b1; tick(1); b_clear = 1'b0;
    for (int n = 0; n < 100 && b_busy; n++) tick(1);
    check("b_clear_done", b_busy, 0);
    pulse(4); tick(5);
    repeat (15) begin pulse(6); tick(10); end
    check("b_overflow_at_15", b_overflow, 0);
    repeat (5) begin pulse(6); tick(10); end
    check("b_overflow_saturated", b_overflow, 1);
    pulse(5); tick(8);
    b_rd_addr = 3'd0; tick(1);
    check("b_bin0_saturated", b_rd_data, 15);
    b_rd_addr = 3'd1; tick(1);
    check("b_bin1_zero", b_rd_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
